// File: rtl/acc_mem_unit_pkg.sv
// ---------------------------------------------------------------------------
// accMemPkg
// Shared definitions for the memory-access stage (acc_mem_unit) and its
// byte-addressable data memory (byteMemMod):
//   - size_e   : access-size encoding (byte / half / word, 11 also means word)
//   - state_e  : FSM state encoding of the access stage
//   - helper functions for alignment checking, byte-enable generation,
//     store-lane replication and load-lane extraction.
// ---------------------------------------------------------------------------
package accMemPkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_WORDX = 2'b11   // reserved encoding, behaves as a word access
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  // Wait counter width; covers the legal latency range 1..15.
  localparam int CNT_W = 4;
  // Byte lanes per 32-bit word.
  localparam int LANES = 4;

  // A half must sit on an even byte, a word on a 4-byte boundary.
  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      default: bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

  // Byte-enable mask for the lanes touched by an access.
  function automatic logic [LANES-1:0] byte_en(input size_e sz, input logic [1:0] lo);
    logic [LANES-1:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data arrives right-aligned; replicate it so every candidate lane
  // carries the value and the byte enables alone pick the destination.
  function automatic logic [31:0] store_lanes(input size_e sz, input logic [31:0] data);
    logic [31:0] w;
    case (sz)
      SZ_BYTE: w = {4{data[7:0]}};
      SZ_HALF: w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  // Pull the addressed lane(s) down to bit 0 and extend; words pass through.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input size_e sz,
                                               input logic [1:0] lo, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: r = {{24{sext & b[7]}}, b};
      SZ_HALF: r = {{16{sext & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/acc_mem_unit_mem.sv
// ---------------------------------------------------------------------------
// byteMemMod
// 2**ADDR_W x DATA_W data memory with per-byte write enables.
// Write is synchronous on the rising clock edge, read is combinational.
// The array has no reset: contents survive a reset of the access stage.
//   clk_i    : clock
//   we_i     : write strobe
//   be_i     : byte-lane enables (bit n -> bits 8n+7:8n)
//   idx_i    : word index
//   wdata_i  : write data, already placed in its lanes
//   rdata_o  : word currently stored at idx_i
// ---------------------------------------------------------------------------
module byteMemMod
  import accMemPkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   idx_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-lane masked write; lanes without an enable keep their contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/acc_mem_unit.sv
// ---------------------------------------------------------------------------
// acc_mem_unit
// Memory-access stage of a simple pipeline: next-PC select plus a
// multi-cycle load/store unit in front of a byte-enabled data memory.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rstN      : asynchronous active-low reset
//   start     : one-cycle pulse launching an access (ignored while busy)
//   condOut   : branch condition, 1 selects aluOOut as next PC
//   datMemRd  : load request
//   datMemWr  : store request (wins if both requests are set)
//   size      : 00 byte, 01 half, 10/11 word
//   signExt   : sign-extend byte/half loads when 1
//   aluOOut   : effective address / branch target
//   npcOut    : sequential next PC
//   regBOut   : right-aligned store data
//   muxFirOut : next-PC select (combinational)
//   lmdOut    : registered load data, held until the next completing load
//   busy      : stage occupied (ACCESS or DONE)
//   done      : one-cycle completion pulse, WAIT_CYC+1 cycles after start
//   err       : misaligned access, valid together with done
//
// Timing: the start edge enters ACCESS with the counter at WAIT_CYC-1. The
// access commits (memory write / lmdOut update) on the edge where ACCESS sees
// the counter at zero, moving to DONE. DONE then raises the registered done
// and err outputs on the following edge, as it hands back to IDLE.
// ---------------------------------------------------------------------------
module acc_mem_unit
  import accMemPkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  input  logic              condOut,
  input  logic              datMemRd,
  input  logic              datMemWr,
  input  logic [1:0]        size,
  input  logic              signExt,
  input  logic [DATA_W-1:0] aluOOut,
  input  logic [DATA_W-1:0] npcOut,
  input  logic [DATA_W-1:0] regBOut,
  output logic [DATA_W-1:0] muxFirOut,
  output logic [DATA_W-1:0] lmdOut,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // FSM state and registered outputs
  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   lmd_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  // Operands captured at start, frozen for the whole access
  logic [DATA_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  size_e               size_q;
  logic                sext_q;
  logic                rd_q;
  logic                wr_q;

  // Datapath between FSM and memory
  logic                misal_s;
  logic                commit_s;
  logic                mem_we_s;
  logic                load_ok_s;
  logic [LANES-1:0]    mem_be_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [DATA_W-1:0]   mem_rdata_s;
  logic [ADDR_W-1:0]   word_idx_s;
  logic [DATA_W-1:0]   load_val_s;
  logic                unused_addr_hi_s;

  // Next-PC select does not depend on the access FSM at all.
  assign muxFirOut = condOut ? aluOOut : npcOut;

  // Bits above the word index are dropped so addresses wrap modulo the depth.
  assign word_idx_s       = addr_q[ADDR_W+1:2];
  assign unused_addr_hi_s = ^addr_q[DATA_W-1:ADDR_W+2];

  assign misal_s   = is_misaligned(size_q, addr_q[1:0]);
  assign commit_s  = (state_q == ST_ACCESS) && (cnt_q == CNT_ZERO);
  // Write strobe is derived from the live state, so an asynchronous reset
  // before the commit edge removes it and the access leaves memory untouched.
  assign mem_we_s  = commit_s & wr_q & ~misal_s;
  // A request with both Rd and Wr set is a store, never a load.
  assign load_ok_s = rd_q & ~wr_q & ~misal_s;

  assign mem_be_s    = byte_en(size_q, addr_q[1:0]);
  assign mem_wdata_s = store_lanes(size_q, data_q);
  assign load_val_s  = load_extract(mem_rdata_s, size_q, addr_q[1:0], sext_q);

  byteMemMod #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we_s),
    .be_i    (mem_be_s),
    .idx_i   (word_idx_s),
    .wdata_i (mem_wdata_s),
    .rdata_o (mem_rdata_s)
  );

  // Access FSM: operand capture, wait counting, load commit, status pulses.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      lmd_q   <= {DATA_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= {DATA_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= aluOOut;
            data_q  <= regBOut;
            size_q  <= size_e'(size);
            sext_q  <= signExt;
            rd_q    <= datMemRd;
            wr_q    <= datMemWr;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == CNT_ZERO) begin
            if (load_ok_s) begin
              lmd_q <= load_val_s;
            end
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          // Only a real load or store can be misaligned.
          err_q   <= misal_s & (rd_q | wr_q);
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign lmdOut = lmd_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_acc_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_acc_mem_unit
// Scoreboard bench for acc_mem_unit with WAIT_CYC=3, ADDR_W=8. Each launched
// access pushes its expected lmdOut/err; a negedge monitor pops and compares
// on every done pulse, also checking the start-to-done latency.
// ---------------------------------------------------------------------------
module tb_acc_mem_unit;

  localparam int W = 3;

  logic        clk;
  logic        rstN;
  logic        start;
  logic        condOut;
  logic        datMemRd;
  logic        datMemWr;
  logic [1:0]  size;
  logic        signExt;
  logic [31:0] aluOOut;
  logic [31:0] npcOut;
  logic [31:0] regBOut;
  logic [31:0] muxFirOut;
  logic [31:0] lmdOut;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [31:0] lmd;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   cyc      = 0;
  int   start_cyc = 0;
  int   done_before;

  acc_mem_unit #(
    .DATA_W   (32),
    .ADDR_W   (8),
    .WAIT_CYC (W)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .start     (start),
    .condOut   (condOut),
    .datMemRd  (datMemRd),
    .datMemWr  (datMemWr),
    .size      (size),
    .signExt   (signExt),
    .aluOOut   (aluOOut),
    .npcOut    (npcOut),
    .regBOut   (regBOut),
    .muxFirOut (muxFirOut),
    .lmdOut    (lmdOut),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending access.
  always @(negedge clk) begin
    if (rstN && done) begin
      n_done++;
      chk("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_lmd"}, lmdOut, mon_e.lmd);
        chk({mon_e.tag, "_err"}, {31'd0, err}, {31'd0, mon_e.err});
        chk({mon_e.tag, "_lat"}, 32'(cyc - start_cyc), 32'(W + 1));
      end
    end
  end

  task automatic do_op(input string tag, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic sx,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_lmd, input logic exp_err,
                       input bit glitch);
    bit   seen;
    exp_t e;
    @(negedge clk);
    aluOOut  = addr;
    regBOut  = data;
    size     = sz;
    signExt  = sx;
    datMemRd = rd;
    datMemWr = wr;
    start    = 1'b1;
    e.lmd = exp_lmd;
    e.err = exp_err;
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    start_cyc = cyc;
    start     = 1'b0;
    // Disturb every operand input while the access is in flight.
    regBOut  = $urandom;
    size     = 2'($urandom);
    signExt  = ~sx;
    datMemRd = ~rd;
    datMemWr = ~wr;
    aluOOut  = 32'h40;
    npcOut   = 32'h24;
    condOut  = 1'b1;
    #1;
    chk({tag, "_mux1"}, muxFirOut, 32'h40);
    condOut = 1'b0;
    #1;
    chk({tag, "_mux0"}, muxFirOut, 32'h24);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      start = (glitch && i == 0);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rstN     = 1'b0;
    start    = 1'b0;
    condOut  = 1'b0;
    datMemRd = 1'b0;
    datMemWr = 1'b0;
    size     = 2'b00;
    signExt  = 1'b0;
    aluOOut  = 32'h0;
    npcOut   = 32'h0;
    regBOut  = 32'h0;
    #1;
    chk("rst_lmd",  lmdOut, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err",  {31'd0, err},  32'd0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;

    // Next-PC select while idle
    aluOOut = 32'h40;
    npcOut  = 32'h24;
    condOut = 1'b1;
    #1;
    chk("idle_mux1", muxFirOut, 32'h40);
    condOut = 1'b0;
    #1;
    chk("idle_mux0", muxFirOut, 32'h24);

    //     tag        rd    wr    size   sx    addr       data          lmd           err  glitch
    do_op("sw10",     1'b0, 1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0);
    do_op("lw10",     1'b1, 1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    do_op("sb13",     1'b0, 1'b1, 2'b00, 1'b0, 32'h13,  32'h12345680, 32'hDEADBEEF, 1'b0, 1'b0);
    do_op("lbs13",    1'b1, 1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0, 1'b0);
    do_op("lbz13",    1'b1, 1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        32'h00000080, 1'b0, 1'b0);
    do_op("lw10b",    1'b1, 1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0, 1'b0);
    do_op("lh11mis",  1'b1, 1'b0, 2'b01, 1'b1, 32'h11,  32'h0,        32'h80ADBEEF, 1'b1, 1'b0);
    do_op("sw12mis",  1'b0, 1'b1, 2'b10, 1'b0, 32'h12,  32'h0,        32'h80ADBEEF, 1'b1, 1'b0);
    do_op("lw10c",    1'b1, 1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0, 1'b0);
    do_op("lhs12",    1'b1, 1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'hFFFF80AD, 1'b0, 1'b0);
    do_op("lhz10",    1'b1, 1'b0, 2'b01, 1'b0, 32'h10,  32'h0,        32'h0000BEEF, 1'b0, 1'b0);
    do_op("lbs11",    1'b1, 1'b0, 2'b00, 1'b1, 32'h11,  32'h0,        32'hFFFFFFBE, 1'b0, 1'b0);
    do_op("sh12",     1'b0, 1'b1, 2'b01, 1'b0, 32'h12,  32'hFFFF1234, 32'hFFFFFFBE, 1'b0, 1'b0);
    do_op("lw10d",    1'b1, 1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h1234BEEF, 1'b0, 1'b0);
    do_op("rdwr14",   1'b1, 1'b1, 2'b10, 1'b1, 32'h14,  32'hCAFEF00D, 32'h1234BEEF, 1'b0, 1'b0);
    do_op("lw14",     1'b1, 1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        32'hCAFEF00D, 1'b0, 1'b0);
    do_op("nop14",    1'b0, 1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        32'hCAFEF00D, 1'b0, 1'b0);

    done_before = n_done;
    do_op("swwrap",   1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A55A5A, 32'hCAFEF00D, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    chk("single_done", 32'(n_done - done_before), 32'd1);
    do_op("lw0",      1'b1, 1'b0, 2'b10, 1'b0, 32'h0,   32'h0,        32'hA5A55A5A, 1'b0, 1'b0);
    do_op("lsz3",     1'b1, 1'b0, 2'b11, 1'b1, 32'h10,  32'h0,        32'h1234BEEF, 1'b0, 1'b0);
    do_op("sw20",     1'b0, 1'b1, 2'b10, 1'b0, 32'h20,  32'h5555AAAA, 32'h1234BEEF, 1'b0, 1'b0);
    do_op("lw20",     1'b1, 1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h5555AAAA, 1'b0, 1'b0);

    // Store aborted by reset in the middle of ACCESS
    @(negedge clk);
    aluOOut  = 32'h20;
    regBOut  = 32'h77777777;
    size     = 2'b10;
    datMemRd = 1'b0;
    datMemWr = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    rstN = 1'b0;
    #1;
    chk("abort_lmd",  lmdOut, 32'h0);
    chk("abort_busy0", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_err",  {31'd0, err},  32'd0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    do_op("lw20post", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h5555AAAA, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_mem_unit.md
ACC_MEM_UNIT -- requirements
Module: acc_mem_unit

Interface
REQ-001 Parameter DATA_W, default 32, data and address width in bits (only 32 supported).
REQ-002 Parameter ADDR_W, default 8, word-index width; memory depth is 2**ADDR_W words.
REQ-003 Parameter WAIT_CYC, default 1, memory access latency in cycles (legal range 1..15).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rstN  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse launching the memory-access stage of the current instruction.
REQ-007 condOut  in  1  branch condition; 1 selects aluOOut as next PC.
REQ-008 datMemRd  in  1  load request.
REQ-009 datMemWr  in  1  store request.
REQ-010 size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-011 signExt  in  1  load result is sign-extended when 1 and zero-extended when 0.
REQ-012 aluOOut  in  32  effective address and branch target.
REQ-013 npcOut  in  32  sequential next PC.
REQ-014 regBOut  in  32  store data, right-aligned.
REQ-015 muxFirOut  out  32  next-PC select.
REQ-016 lmdOut  out  32  registered load data.
REQ-017 busy  out  1  stage occupied.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 err  out  1  misaligned-access flag, valid with done.

Function
REQ-020 muxFirOut SHALL be combinational: condOut ? aluOOut : npcOut, independent of the FSM.
REQ-021 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-022 In IDLE, start=1 SHALL capture address, data, size, signExt, Rd and Wr, load the wait counter with WAIT_CYC-1, and enter ACCESS.
REQ-023 start SHALL be ignored while busy; captured operands SHALL be unaffected by input changes during ACCESS and DONE.
REQ-024 In ACCESS, the counter SHALL decrement each cycle; when it reaches 0 the access commits and the FSM enters DONE.
REQ-025 In DONE, done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-026 done SHALL rise exactly WAIT_CYC+1 cycles after the start edge; busy=1 in ACCESS and DONE only.
REQ-027 Word index SHALL be addr[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo depth.
REQ-028 Store: byte writes lane addr[1:0] with regBOut[7:0]; half writes lanes {addr[1],0} and {addr[1],1} with regBOut[15:0]; word writes all lanes; all other bytes are preserved.
REQ-029 Load: the addressed lane(s) SHALL be right-aligned and extended per signExt into lmdOut on entry to DONE; word loads ignore signExt.
REQ-030 Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0): no memory write, lmdOut unchanged, err=1 with done.
REQ-031 Rd and Wr both set: treated as a store; lmdOut unchanged.
REQ-032 Neither Rd nor Wr set: no memory access, lmdOut unchanged, done still issued with the same latency.
REQ-033 lmdOut SHALL hold its value until the next completing load.

Reset
REQ-034 rstN=0 SHALL immediately force IDLE, lmdOut=0, busy=0, done=0, err=0 and counter=0.
REQ-035 Reset asserted before the commit cycle SHALL abort the access with no memory write; memory contents are not reset.

Structure
REQ-036 Size encodings and the FSM state encoding SHALL live in a shared package, accMemPkg.
REQ-037 A single sub-module, byteMemMod, SHALL hold the 2**ADDR_W x 32 array with 4-bit byte-enable synchronous write and combinational read.

Verification
REQ-038 WAIT_CYC=3; word store 0xDEADBEEF @0x10, then word load @0x10 -> done 4 cycles after each start, lmdOut=0xDEADBEEF, err=0.
REQ-039 Byte store 0x80 @0x13, then load byte signExt=1 @0x13 -> lmdOut=0xFFFFFF80; signExt=0 -> 0x00000080; word @0x10 -> 0x80ADBEEF.
REQ-040 Half load @0x11 -> err=1 with done, lmdOut unchanged, memory unchanged.
REQ-041 condOut=1, aluOOut=0x40, npcOut=0x24 -> muxFirOut=0x40; condOut=0 -> 0x24, in any FSM state.
REQ-042 start pulsed again during ACCESS -> ignored, single done; rstN low mid-ACCESS of a store -> outputs zero, target word unchanged.
REQ-043 ADDR_W=8, word store @0x400 -> lands at index 0 (wrap); a subsequent load @0x0 returns the stored value.
